// File: rtl/servo_pkg.sv
// Shared constants and elaboration helpers for the multi-channel servo PWM block.
package servo_pkg;

    localparam int SERVOMIN_DEF     = 124;
    localparam int SERVOMAX_DEF     = 543;
    localparam int PERIOD_TICKS_DEF = 4096;
    localparam int TICK_DIV_DEF     = 1221;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int span(input int smin, input int smax);
        return smax - smin;
    endfunction

    function automatic int prod_w(input int angle_w, input int smin, input int smax);
        return angle_w + $clog2(smax - smin + 1);
    endfunction

    function automatic int center(input int smin, input int smax);
        return smin + ((smax - smin) >> 1);
    endfunction

    // Channel index width leaves room to encode an out-of-range channel.
    function automatic int ch_w(input int nch);
        return $clog2(nch + 1);
    endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// Angle write bus between the controller (master) and the servo PWM block (slave).
interface servo_pwm_multi_if
    import servo_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int ANGLE_W = 12
);
    localparam int CH_W = ch_w(NCH);

    logic               wr_en;
    logic [CH_W-1:0]    wr_ch;
    logic [ANGLE_W-1:0] wr_angle;
    logic               busy;

    modport master (output wr_en, wr_ch, wr_angle, input  busy);
    modport slave  (input  wr_en, wr_ch, wr_angle, output busy);

endinterface

// File: rtl/servo_angle_scale.sv
// Two-stage angle scaler: S1 applies channel reversal and registers the command,
// S2 scales it to a pulse width for the target write-back; ch rides as sideband.
module servo_angle_scale
    import servo_pkg::*;
#(
    parameter int             NCH           = 4,
    parameter int             ANGLE_W       = 12,
    parameter int             SERVOMIN      = SERVOMIN_DEF,
    parameter int             SERVOMAX      = SERVOMAX_DEF,
    parameter logic [NCH-1:0] REVERSED_MASK = '0,
    parameter int             CH_W          = ch_w(NCH),
    parameter int             WID_W         = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_vld,
    input  logic [CH_W-1:0]    in_ch,
    input  logic [ANGLE_W-1:0] in_angle,
    output logic               out_vld,
    output logic [CH_W-1:0]    out_ch,
    output logic [WID_W-1:0]   out_width,
    output logic               busy
);
    localparam int SPAN = span(SERVOMIN, SERVOMAX);
    localparam int PW   = prod_w(ANGLE_W, SERVOMIN, SERVOMAX);

    logic [2:1]         vld_pipe;
    logic               in_ok;
    logic               rev_sel;
    logic [ANGLE_W-1:0] a_q;
    logic [CH_W-1:0]    ch_q;
    logic [PW-1:0]      prod;

    assign in_ok = in_vld && (in_ch < CH_W'(NCH));

    always_comb begin
        rev_sel = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (in_ch == CH_W'(i)) rev_sel = REVERSED_MASK[i];
    end

    // vld_pipe[2] marks the write-back cycle so busy covers both stages.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            a_q      <= '0;
            ch_q     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], in_ok};
            if (in_ok) begin
                a_q  <= rev_sel ? ~in_angle : in_angle;
                ch_q <= in_ch;
            end
        end
    end

    assign prod      = PW'(a_q) * PW'(SPAN);
    assign out_width = WID_W'(SERVOMIN) + WID_W'(prod >> ANGLE_W);
    assign out_vld   = vld_pipe[1];
    assign out_ch    = ch_q;
    assign busy      = |vld_pipe;

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM: shared prescaler/frame counter, double-buffered widths
// committed at frame start. Define SERVO_SLEW_EN to rate-limit width changes per frame.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int             NCH           = 4,
    parameter int             ANGLE_W       = 12,
    parameter int             SERVOMIN      = SERVOMIN_DEF,
    parameter int             SERVOMAX      = SERVOMAX_DEF,
    parameter logic [NCH-1:0] REVERSED_MASK = '0,
    parameter int             TICK_DIV      = TICK_DIV_DEF,
    parameter int             PERIOD_TICKS  = PERIOD_TICKS_DEF,
    parameter int             SLEW_STEP     = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    servo_pwm_multi_if.slave      wr,
    output logic                  frame_start,
    output logic [NCH-1:0]        pwm
);
    localparam int FW   = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
    localparam int PSW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CH_W = ch_w(NCH);
    localparam logic [FW-1:0] CENTER_W = FW'(center(SERVOMIN, SERVOMAX));

    if (!(SERVOMAX < PERIOD_TICKS && SERVOMIN <= SERVOMAX)) begin : g_bad_width
        $error("servo_pwm_multi: need SERVOMIN <= SERVOMAX < PERIOD_TICKS");
    end
    if (NCH < 1 || NCH > 16 || SLEW_STEP < 1) begin : g_bad_cfg
        $error("servo_pwm_multi: NCH must be 1..16 and SLEW_STEP >= 1");
    end

    state_t          state, state_nxt;
    logic            commit;
    logic            run;
    logic            tick;
    logic [PSW-1:0]  prescaler;
    logic [FW-1:0]   frame_cnt;
    logic            sc_vld;
    logic [CH_W-1:0] sc_ch;
    logic [FW-1:0]   sc_width;

    servo_angle_scale #(
        .NCH(NCH), .ANGLE_W(ANGLE_W), .SERVOMIN(SERVOMIN), .SERVOMAX(SERVOMAX),
        .REVERSED_MASK(REVERSED_MASK), .CH_W(CH_W), .WID_W(FW)
    ) u_scale (
        .clock(clock), .reset(reset),
        .in_vld(wr.wr_en), .in_ch(wr.wr_ch), .in_angle(wr.wr_angle),
        .out_vld(sc_vld), .out_ch(sc_ch), .out_width(sc_width), .busy(wr.busy)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            ST_IDLE: if (enable) begin
                state_nxt = ST_RUN;
                commit    = 1'b1;
            end
            ST_RUN: if (!enable) state_nxt = ST_IDLE;
                    else if (tick && frame_cnt == FW'(PERIOD_TICKS - 1)) commit = 1'b1;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The commit cycle out of IDLE keeps the timebase at zero so frame 0 starts clean.
    assign run  = enable && (state == ST_RUN);
    assign tick = (prescaler == PSW'(TICK_DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler   <= '0;
            frame_cnt   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= commit;
            if (!run) begin
                prescaler <= '0;
                frame_cnt <= '0;
            end else begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (tick)
                    frame_cnt <= (frame_cnt == FW'(PERIOD_TICKS - 1)) ? '0 : frame_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [FW-1:0] tgt_q, act_q, act_nxt;
        logic          pwm_q;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset)                                 tgt_q <= CENTER_W;
            else if (sc_vld && sc_ch == CH_W'(i))       tgt_q <= sc_width;
        end

`ifdef SERVO_SLEW_EN
        localparam logic [FW-1:0] STEP_W = FW'(SLEW_STEP);
        always_comb begin
            act_nxt = tgt_q;
            if (tgt_q > act_q) begin
                if (tgt_q - act_q > STEP_W) act_nxt = act_q + STEP_W;
            end else if (act_q - tgt_q > STEP_W) begin
                act_nxt = act_q - STEP_W;
            end
        end
`else
        assign act_nxt = tgt_q;
`endif

        // A target landing on the commit edge is sampled old; it waits a frame.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                act_q <= CENTER_W;
                pwm_q <= 1'b0;
            end else begin
                if (commit) act_q <= act_nxt;
                pwm_q <= enable && (frame_cnt < act_q);
            end
        end

        assign pwm[i] = pwm_q;
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench for servo_pwm_multi: stimulus queues expected per-frame widths,
// a monitor measures pulse widths over each complete frame and compares.
module tb_servo_pwm_multi;
    import servo_pkg::*;

    localparam int NCH = 4;
    typedef logic [NCH-1:0][15:0] wvec_t;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           enable = 1'b0;
    logic           frame_start;
    logic [NCH-1:0] pwm;

    servo_pwm_multi_if #(.NCH(NCH), .ANGLE_W(12)) wr_bus ();

    servo_pwm_multi #(
        .NCH(NCH), .ANGLE_W(12), .TICK_DIV(1), .REVERSED_MASK(4'b0100)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .wr(wr_bus),
        .frame_start(frame_start), .pwm(pwm)
    );

    always #5 clock = ~clock;

    int    checks = 0;
    int    failures = 0;
    wvec_t exp_q[$];
    int    cnt[NCH];
    bit    in_frame = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic wvec_t mk(input int w0, input int w1, input int w2, input int w3);
        wvec_t v;
        v[0] = 16'(w0); v[1] = 16'(w1); v[2] = 16'(w2); v[3] = 16'(w3);
        return v;
    endfunction

    // Monitor: a frame counts only if it runs uninterrupted from one frame_start to the next.
    always @(negedge clock) begin
        if (!reset || !enable) begin
            in_frame = 1'b0;
        end else if (frame_start) begin
            if (in_frame) begin
                check("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    wvec_t e;
                    e = exp_q.pop_front();
                    for (int i = 0; i < NCH; i++)
                        check($sformatf("width_ch%0d", i), cnt[i], e[i]);
                end
            end
            in_frame = 1'b1;
            for (int i = 0; i < NCH; i++) cnt[i] = 0;
        end else if (in_frame) begin
            for (int i = 0; i < NCH; i++) cnt[i] += int'(pwm[i]);
        end
    end

    task automatic wait_frame(input bit push, input wvec_t e, output int waited);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (!frame_start && waited < 5000);
        check("frame_start_seen", frame_start, 1);
        if (push) exp_q.push_back(e);
    endtask

    task automatic wr(input int ch, input int ang);
        wr_bus.wr_ch    = 3'(ch);
        wr_bus.wr_angle = 12'(ang);
        wr_bus.wr_en    = 1'b1;
        @(negedge clock);
    endtask

    task automatic wr_idle();
        wr_bus.wr_en = 1'b0;
    endtask

    initial begin
        int w;
        wr_bus.wr_en = 1'b0; wr_bus.wr_ch = '0; wr_bus.wr_angle = '0;
        repeat (3) @(negedge clock);
        check("rst_pwm", pwm, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_busy", wr_bus.busy, 0);

        reset = 1'b1; enable = 1'b1;
        wait_frame(1, mk(333, 333, 333, 333), w);          // F0
        check("first_frame_latency", w, 1);
        repeat (1000) @(negedge clock);
        wr(0, 2048); wr(1, 0); wr(3, 4095); wr_idle();
        check("busy_after_1", wr_bus.busy, 1);
        @(negedge clock); check("busy_after_2", wr_bus.busy, 1);
        @(negedge clock); check("busy_after_3", wr_bus.busy, 0);

        wait_frame(1, mk(333, 124, 333, 542), w);          // F1
        repeat (500) @(negedge clock);
        wr(2, 0); wr_idle();
        wait_frame(1, mk(333, 124, 542, 542), w);          // F2
        repeat (500) @(negedge clock);
        wr(2, 4095); wr_idle();
        wait_frame(1, mk(333, 124, 124, 542), w);          // F3
        repeat (4094) @(negedge clock);
        wr(0, 0); wr_idle();                               // target lands on commit edge
        wait_frame(1, mk(333, 124, 124, 542), w);          // F4
        repeat (200) @(negedge clock);
        wr(5, 0); wr_idle();
        check("busy_bad_ch_1", wr_bus.busy, 0);
        @(negedge clock); check("busy_bad_ch_2", wr_bus.busy, 0);
        @(negedge clock); check("busy_bad_ch_3", wr_bus.busy, 0);
        wait_frame(1, mk(124, 124, 124, 542), w);          // F5

        wait_frame(0, mk(0, 0, 0, 0), w);                  // F6, truncated
        repeat (100) @(negedge clock);
        check("pwm_before_disable", pwm, 4'b1111);
        enable = 1'b0;
        @(negedge clock); check("pwm_after_disable", pwm, 0);
        wr(1, 2048); wr_idle();
        repeat (5) @(negedge clock);
        check("pwm_idle", pwm, 0);
        check("frame_start_idle", frame_start, 0);
        enable = 1'b1;
        wait_frame(1, mk(124, 333, 124, 542), w);          // F7
        check("enable_rise_latency", w, 1);

        wait_frame(0, mk(0, 0, 0, 0), w);                  // F8, truncated by reset
        repeat (10) @(negedge clock);
        wr(0, 4095); wr_idle();
        repeat (40) @(negedge clock);
        check("pwm_before_reset", pwm, 4'b1111);
        reset = 1'b0;
        #1;
        check("pwm_async_reset", pwm, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        wait_frame(1, mk(333, 333, 333, 333), w);          // F9
        check("reset_release_latency", w, 1);

        wait_frame(0, mk(0, 0, 0, 0), w);                  // F10 closes F9
        @(negedge clock);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
